muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Iterative multiply/divide controller for the pipelined MIPS core, executing MULT, MULTU, DIV and DIVU over 33 cycles on a shared shift/add-subtract datapath. It owns the HI/LO registers. It exports `busy` so hazard logic can stall any later muldiv issue or HI/LO read until the result is committed. It sits beside the EX-stage ALU and is launched from EX by the decoder's muldiv opcode.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  launch request; sampled only when idle.
- `op`  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_val`  in  WIDTH  multiplicand or dividend.
- `rt_val`  in  WIDTH  multiplier or divisor.
- `mthi`  in  1  write `rs_val` to HI.
- `mtlo`  in  1  write `rs_val` to LO.
- `hi`  out  WIDTH  HI register: product upper half, or remainder.
- `lo`  out  WIDTH  LO register: product lower half, or quotient.
- `busy`  out  1  operation in flight; the pipeline stalls on muldiv/MFHI/MFLO while high.
- `done`  out  1  one-cycle pulse when HI/LO are committed.

## Operation
- **FSM states:** IDLE, CALC, FIX.
- **IDLE:**
  - If `start`=1: latch `op`; latch |rs_val| and |rt_val| (magnitudes for signed ops, raw values for unsigned ops); latch result sign and remainder sign; clear the accumulator; set count=0; go to CALC.
  - Else if `mthi`/`mtlo` is set: write `rs_val` to HI/LO. Both may be set together.
- **CALC, multiply:** shift-add, one multiplier bit per cycle, into a 2·WIDTH accumulator.
- **CALC, divide:** restoring division, one quotient bit per cycle.
- **CALC exit:** count increments each cycle; after count reaches WIDTH-1, go to FIX.
- **FIX:**
  - Apply two's-complement negation where needed.
  - Multiply: negate the 2·WIDTH product if the operand signs differ (signed only).
  - Divide: negate the quotient if the signs differ; negate the remainder if the dividend was negative (signed only).
  - Write HI/LO, pulse `done`, return to IDLE.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH per half; no exceptions are raised.
  - Signed −2^31 / −1 gives LO=0x80000000, HI=0.
  - Divide by zero, both signed and unsigned: LO=all ones, HI=`rs_val` as latched, with no sign fixup.
- **Ignored inputs:**
  - `start` while busy is ignored; no queuing.
  - `mthi`/`mtlo` while busy are ignored.
  - `start` together with `mthi`/`mtlo` in IDLE: `start` wins and the moves are dropped.
- **Reset, including mid-operation:** state=IDLE, count=0, HI=0, LO=0, busy=0, done=0. Partial results are discarded.

## Timing
- **Reset values:** `hi`=0, `lo`=0, `busy`=0, `done`=0.
- **Accept edge E0:** `start` is accepted at edge E0 in IDLE; `busy`=1 from E0 onward.
- **CALC:** edges E1..E32.
- **FIX:** edge E33 writes HI/LO. After E33: `busy`=0, `done`=1 for exactly one cycle, new HI/LO visible.
- **Latency:** 33 cycles from accept to result.
- **Back-to-back:** a new `start` can be accepted at E33+1 (the cycle `done` is high), giving a throughput of one operation per 34 cycles.
- **Move writes:** `mthi`/`mtlo` in IDLE update the output at the next edge (1-cycle latency).
- **Output stability:** HI/LO hold their previous values throughout CALC. Intermediate accumulator state is never driven onto `hi`/`lo`.
- **Register-driven outputs:** `busy` and `done` are registered; there is no combinational path from `start` to `busy`.

## Test plan
- **MULT 7 × 6:** result 33 cycles after accept is HI=0x00000000, LO=0x0000002A. `done` is high for 1 cycle, and `busy` is high for exactly 33 cycles.
- **Signed/unsigned multiply:**
  - MULT −3 × 5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- **Divide, including corners:**
  - DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
  - DIVU 10 / 0 → LO=0xFFFFFFFF, HI=0x0000000A.
- **Start while busy:** a second `start` with different operands at E5 is ignored; the first result is unchanged and `done` pulses once.
- **Moves:**
  - `mthi` with `rs_val`=0x12345678 in IDLE → HI=0x12345678 next cycle, LO unchanged.
  - `mtlo` during CALC → no effect.
  - `mtlo` together with `start` → move dropped.
- **Reset mid-operation:** `reset` at E10 of a DIVU → next cycle HI=0, LO=0, busy=0, done=0, with no `done` pulse later. A fresh MULTU 3 × 4 then yields LO=12.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the EX-stage launch logic and the
// multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, rs_val, rt_val, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_val, rt_val, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// One operand bit per cycle on a shared shift/add-subtract accumulator,
// with sign handling done on magnitudes and a single fixup cycle at the end.
//
// state  | meaning
// IDLE   | waiting for start; mthi/mtlo moves accepted here
// CALC   | WIDTH iterations of shift-add or restoring divide
// FIX    | sign fixup, commit HI/LO, pulse done
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  muldiv_sequencer_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;

  logic               signed_op;
  logic               neg_a;
  logic               neg_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_part;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Operand magnitudes and sign flags for the launch cycle.
  always_comb begin
    signed_op = ~bus.op[0];
    neg_a     = signed_op & bus.rs_val[WIDTH-1];
    neg_b     = signed_op & bus.rt_val[WIDTH-1];
    mag_a     = neg_a ? -bus.rs_val : bus.rs_val;
    mag_b     = neg_b ? -bus.rt_val : bus.rt_val;
  end

  // One iteration: multiply adds into the upper half and shifts right;
  // divide shifts left and subtracts the divisor when it fits.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    div_part = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_part >= {1'b0, operand});
    div_diff = div_part[WIDTH-1:0] - operand;
    if (is_div) begin
      acc_next = {(div_ge ? div_diff : div_part[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};
    end else begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  // Final sign correction; divide-by-zero keeps the raw all-ones quotient
  // and the latched dividend as remainder.
  always_comb begin
    prod_neg = -acc;
    fix_hi   = acc[2*WIDTH-1:WIDTH];
    fix_lo   = acc[WIDTH-1:0];
    if (!is_div) begin
      if (neg_res) begin
        fix_hi = prod_neg[2*WIDTH-1:WIDTH];
        fix_lo = prod_neg[WIDTH-1:0];
      end
    end else if (div_zero) begin
      fix_lo = '1;
    end else begin
      if (neg_res) fix_lo = -acc[WIDTH-1:0];
      if (neg_rem) fix_hi = -acc[2*WIDTH-1:WIDTH];
    end
  end

  // Sequencer state, accumulator and HI/LO registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            is_div   <= bus.op[1];
            neg_res  <= neg_a ^ neg_b;
            neg_rem  <= neg_a;
            div_zero <= bus.op[1] & (bus.rt_val == '0);
            operand  <= bus.op[1] ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
            count    <= '0;
            busy_q   <= 1'b1;
            state    <= S_CALC;
          end else begin
            if (bus.mthi) hi_q <= bus.rs_val;
            if (bus.mtlo) lo_q <= bus.rs_val;
          end
        end
        S_CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) state <= S_FIX;
        end
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a vector table of arithmetic cases
// plus hand-written sequences for moves, overlapping start and reset.
module tb_muldiv_sequencer;
  logic clk;
  logic reset;
  int   tests;
  int   fails;

  muldiv_sequencer_if #(.WIDTH(32)) bus ();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm);
    int g = 0;
    while (!bus.done && g < 100) begin
      tick();
      g++;
    end
    check({nm, "_done_seen"}, 64'(bus.done), 64'd1);
  endtask

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] h0, l0;
    int          bc;
    bit          hold_ok;
    h0 = bus.hi;
    l0 = bus.lo;
    bus.start  = 1'b1;
    bus.op     = o;
    bus.rs_val = a;
    bus.rt_val = b;
    tick();
    bus.start  = 1'b0;
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
    bc = 0;
    hold_ok = 1'b1;
    while (bus.busy && bc < 100) begin
      if (bus.hi !== h0 || bus.lo !== l0 || bus.done !== 1'b0) hold_ok = 1'b0;
      bc++;
      tick();
    end
    check({nm, "_busy_cycles"}, 64'(bc), 64'd33);
    check({nm, "_hold"}, 64'(hold_ok), 64'd1);
    check({nm, "_done"}, 64'(bus.done), 64'd1);
    check({nm, "_hi"}, 64'(bus.hi), 64'(ehi));
    check({nm, "_lo"}, 64'(bus.lo), 64'(elo));
    tick();
    check({nm, "_done_drop"}, 64'(bus.done), 64'd0);
  endtask

  initial begin
    logic [31:0] h_prev, l_prev, cap_hi, cap_lo;
    int          dcount;

    vecs[0] = '{"mult_7x6",      2'b00, 32'd7,        32'd6,        32'h0000_0000, 32'h0000_002A};
    vecs[1] = '{"mult_m3x5",     2'b00, 32'hFFFF_FFFD, 32'd5,       32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{"multu_max",     2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[3] = '{"mult_m4xm4",    2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0010};
    vecs[4] = '{"div_m7d2",      2'b10, 32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[5] = '{"div_7dm2",      2'b10, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[6] = '{"div_min_dm1",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{"divu_10d0",     2'b11, 32'd10,       32'd0,        32'h0000_000A, 32'hFFFF_FFFF};
    vecs[8] = '{"divu_100d7",    2'b11, 32'd100,      32'd7,        32'h0000_0002, 32'h0000_000E};
    vecs[9] = '{"divu_max_d16",  2'b11, 32'hFFFF_FFFF, 32'h10,      32'h0000_000F, 32'h0FFF_FFFF};

    tests = 0;
    fails = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    tick();
    tick();
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);
    end

    // mthi in IDLE
    l_prev = bus.lo;
    bus.mthi = 1'b1;
    bus.rs_val = 32'h1234_5678;
    tick();
    bus.mthi = 1'b0;
    check("mthi_hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi_lo_kept", 64'(bus.lo), 64'(l_prev));

    // mtlo while calculating is ignored
    l_prev = bus.lo;
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd5;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    bus.mtlo = 1'b1;
    bus.rs_val = 32'hDEAD_BEEF;
    tick();
    bus.mtlo = 1'b0;
    check("mtlo_calc_lo", 64'(bus.lo), 64'(l_prev));
    wait_done("mtlo_calc");
    check("mtlo_calc_result", 64'(bus.lo), 64'd15);
    tick();

    // mthi/mtlo together with start are dropped
    h_prev = bus.hi;
    l_prev = bus.lo;
    bus.start = 1'b1;
    bus.mtlo = 1'b1;
    bus.mthi = 1'b1;
    bus.op = 2'b01;
    bus.rs_val = 32'd2;
    bus.rt_val = 32'd3;
    tick();
    bus.start = 1'b0;
    bus.mtlo = 1'b0;
    bus.mthi = 1'b0;
    check("mv_start_lo", 64'(bus.lo), 64'(l_prev));
    check("mv_start_hi", 64'(bus.hi), 64'(h_prev));
    wait_done("mv_start");
    check("mv_start_result", 64'(bus.lo), 64'd6);
    tick();

    // second start at E5 is ignored
    bus.start = 1'b1;
    bus.op = 2'b00;
    bus.rs_val = 32'd7;
    bus.rt_val = 32'd6;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    bus.start = 1'b1;
    bus.op = 2'b01;
    bus.rs_val = 32'd9;
    bus.rt_val = 32'd9;
    tick();
    bus.start = 1'b0;
    dcount = 0;
    cap_hi = '1;
    cap_lo = '1;
    for (int i = 0; i < 60; i++) begin
      if (bus.done) begin
        dcount++;
        cap_hi = bus.hi;
        cap_lo = bus.lo;
      end
      tick();
    end
    check("busy_start_done_cnt", 64'(dcount), 64'd1);
    check("busy_start_hi", 64'(cap_hi), 64'd0);
    check("busy_start_lo", 64'(cap_lo), 64'd42);

    // reset at E10 of a DIVU
    bus.start = 1'b1;
    bus.op = 2'b11;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_hi", 64'(bus.hi), 64'd0);
    check("midrst_lo", 64'(bus.lo), 64'd0);
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    dcount = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.done) dcount++;
      tick();
    end
    check("midrst_no_done", 64'(dcount), 64'd0);
    run_op("post_rst_multu_3x4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
